// File: rtl/prog_loader_if.sv
// Program-stream handshake and RAM write port of the boot-time program loader.
// master = program source / RAM side, slave = the loader.
interface prog_loader_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
);
    logic                 in_valid;
    logic [WORD_SIZE-1:0] in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: zero-fills the MCPU instruction RAM, streams a program
// into it from address 0, then releases the CPU from reset.
//
// state     | meaning
// S_CLEAR   | writing 0 to every RAM word, cnt = address being cleared
// S_LOAD    | accepting program words, cnt = next write address
// S_RELEASE | last word on the write port, CPU still held
// S_RUN     | program committed, CPU running
// S_ERROR   | program longer than the RAM, CPU held
module prog_loader #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8,
    parameter int RAM_SIZE  = 256
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         done,
    output logic         error
);
    localparam int CNT_W = ADDR_SIZE + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(RAM_SIZE - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 we_q, we_nx;
    logic [ADDR_SIZE-1:0] addr_q, addr_nx;
    logic [WORD_SIZE-1:0] wdata_q, wdata_nx;
    logic                 cpu_reset_q, cpu_reset_nx;
    logic                 done_q, done_nx;
    logic                 error_q, error_nx;
    logic                 ready;
    logic                 hs;

    assign ready        = (state == S_LOAD);
    assign hs           = bus.in_valid & ready;

    assign bus.in_ready  = ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_reset     = cpu_reset_q;
    assign done          = done_q;
    assign error         = error_q;

    // Outputs are registered from the current state, so done/cpu_reset change
    // on the edge after RUN is entered, i.e. two edges after the last handshake.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        we_nx        = 1'b0;
        addr_nx      = addr_q;
        wdata_nx     = wdata_q;
        cpu_reset_nx = 1'b1;
        done_nx      = 1'b0;
        error_nx     = 1'b0;
        case (state)
            S_CLEAR: begin
                we_nx    = 1'b1;
                addr_nx  = cnt[ADDR_SIZE-1:0];
                wdata_nx = '0;
                if (cnt == LAST_ADDR) begin
                    cnt_nx   = '0;
                    state_nx = S_LOAD;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_LOAD: begin
                if (hs) begin
                    we_nx    = 1'b1;
                    addr_nx  = cnt[ADDR_SIZE-1:0];
                    wdata_nx = bus.in_data;
                    cnt_nx   = cnt + CNT_W'(1);
                    if (bus.in_last) begin
                        state_nx = S_RELEASE;
                    end else if (cnt == LAST_ADDR) begin
                        state_nx = S_ERROR;
                    end
                end
            end
            S_RELEASE: begin
                state_nx = S_RUN;
            end
            S_RUN: begin
                cpu_reset_nx = 1'b0;
                done_nx      = 1'b1;
            end
            S_ERROR: begin
                error_nx = 1'b1;
            end
            default: begin
                state_nx = S_CLEAR;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_CLEAR;
            cnt         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            we_q        <= we_nx;
            addr_q      <= addr_nx;
            wdata_q     <= wdata_nx;
            cpu_reset_q <= cpu_reset_nx;
            done_q      <= done_nx;
            error_q     <= error_nx;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random programs against an array/queue
// model of the RAM image and write order, plus clear, overflow and reset cases.
module tb_prog_loader;
    localparam int WS = 16;
    localparam int AS = 8;
    localparam int RS = 256;
    localparam logic [3:0] OP_SHORT_TO_REG = 4'h1;
    localparam logic [3:0] OP_ADD          = 4'h2;
    localparam logic [3:0] OP_XOR          = 4'h3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_reset, done, error;
    int   vectors = 0;
    int   miscompares = 0;

    prog_loader_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus ();

    prog_loader #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .RAM_SIZE(RS)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    logic [WS-1:0]      ram     [RS];
    logic [WS-1:0]      exp_ram [RS];
    logic [WS-1:0]      prog    [300];
    logic [AS+WS-1:0]   wlog    [$];

    // The bench plays the RAM: every write seen on the port lands here.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            ram[bus.mem_addr] = bus.mem_wdata;
            wlog.push_back({bus.mem_addr, bus.mem_wdata});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp(input int n);
        for (int i = 0; i < RS; i++) exp_ram[i] = '0;
        for (int i = 0; i < n && i < RS; i++) exp_ram[i] = prog[i];
    endtask

    function automatic int ram_errors();
        int e = 0;
        for (int i = 0; i < RS; i++) if (ram[i] !== exp_ram[i]) e++;
        return e;
    endfunction

    function automatic int wlog_errors(input int base, input int n);
        int e = 0;
        if (wlog.size() - base != n) e++;
        for (int i = 0; i < n && base + i < wlog.size(); i++)
            if (wlog[base + i] !== {AS'(i), prog[i]}) e++;
        return e;
    endfunction

    // Pulse reset for one edge, then wait for the clear pass to finish.
    task automatic start_clear(input bit pre_valid, input bit pre_last,
                               output int cycles, output bit stayed);
        reset = 1'b1;
        bus.in_valid = pre_valid;
        bus.in_data  = prog[0];
        bus.in_last  = pre_last;
        step();
        reset  = 1'b0;
        cycles = 0;
        stayed = 1'b1;
        while (bus.in_ready !== 1'b1 && cycles < 300) begin
            step();
            cycles++;
            if (cpu_reset !== 1'b1 || done !== 1'b0) stayed = 1'b0;
        end
    endtask

    task automatic drive_prog(input int n, input bit use_last, input int gap,
                              input int limit, output int accepted, output int cycles);
        bit hs;
        accepted = 0;
        cycles   = 0;
        while (cycles < limit && !(use_last && accepted == n)) begin
            if (bus.in_valid !== 1'b1) begin
                if (accepted < n && $urandom_range(99) >= gap) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = prog[accepted];
                    bus.in_last  = use_last && (accepted == n - 1);
                end else begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = WS'($urandom);
                    bus.in_last  = 1'($urandom_range(1));
                end
            end
            hs = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
            step();
            cycles++;
            if (hs) begin
                accepted++;
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_program(input string name, input int n, input int gap);
        int  cyc, acc, base, e;
        bit  stayed;
        build_exp(n);
        start_clear(gap == 0, n == 1, cyc, stayed);
        base = wlog.size() + 1;   // write to the last RAM address is still on the port
        drive_prog(n, 1'b1, gap, 4 * n + 50, acc, cyc);
        vectors++;
        if (acc != n || (gap == 0 && cyc != n))
            $display("FAIL %s_accept: got %0d words in %0d cycles, expected %0d", name, acc, cyc, n);
        if (acc != n || (gap == 0 && cyc != n)) miscompares++;
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== AS'(n - 1) || bus.mem_wdata !== prog[n - 1]) begin
            miscompares++;
            $display("FAIL %s_last_write: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                     name, bus.mem_we, bus.mem_addr, bus.mem_wdata, AS'(n - 1), prog[n - 1]);
        end
        step();
        vectors++;
        if (done !== 1'b0 || cpu_reset !== 1'b1 || bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_release: got done=%b cpu_reset=%b we=%b ready=%b expected 0 1 0 0",
                     name, done, cpu_reset, bus.mem_we, bus.in_ready);
        end
        step();
        vectors++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_run: got done=%b cpu_reset=%b error=%b expected 1 0 0",
                     name, done, cpu_reset, error);
        end
        vectors++;
        e = ram_errors();
        if (e != 0) begin
            miscompares++;
            $display("FAIL %s_ram: got %0d differing words expected 0", name, e);
        end
        vectors++;
        e = wlog_errors(base, n);
        if (e != 0) begin
            miscompares++;
            $display("FAIL %s_writes: got %0d bad/missing writes of %0d expected 0", name, e, wlog.size() - base);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = WS'($urandom);
        bus.in_last  = 1'b1;
        step();
        step();
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_mem: got we=%b addr=%h data=%h expected 0 0 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 0", bus.in_ready);
        end
        vectors++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got cpu_reset=%b done=%b error=%b expected 1 0 0",
                     cpu_reset, done, error);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_clear();
        int cyc, base, e;
        bit stayed;
        base = wlog.size();
        start_clear(1'b0, 1'b0, cyc, stayed);
        vectors++;
        if (cyc != RS) begin
            miscompares++;
            $display("FAIL clear_length: got in_ready after %0d cycles expected %0d", cyc, RS);
        end
        vectors++;
        if (!stayed) begin
            miscompares++;
            $display("FAIL clear_cpu_reset: got cpu_reset low or done high during clear expected held");
        end
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== AS'(RS - 1) || bus.mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL clear_last_write: got we=%b addr=%h data=%h expected 1 ff 0000",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        e = 0;
        if (wlog.size() - base != RS) e++;
        for (int i = 0; i < RS && base + i < wlog.size(); i++)
            if (wlog[base + i] !== {AS'(i), WS'(0)}) e++;
        vectors++;
        if (e != 0) begin
            miscompares++;
            $display("FAIL clear_writes: got %0d bad writes of %0d expected 0", e, wlog.size() - base);
        end
        vectors++;
        if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_idle: got we=%b ready=%b expected 0 1", bus.mem_we, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [WS-1:0] r [16];
        logic [WS-1:0] w;
        prog[0] = {OP_SHORT_TO_REG, 4'h0, 8'h20};
        prog[1] = {OP_SHORT_TO_REG, 4'h1, 8'h02};
        prog[2] = {OP_ADD, 4'h4, 4'h0, 4'h1};
        prog[3] = {OP_XOR, 4'h5, 4'h0, 4'h1};
        run_program("b2b", 4, 0);
        for (int i = 0; i < 16; i++) r[i] = '0;
        for (int pc = 0; pc < 4; pc++) begin
            w = ram[pc];
            case (w[15:12])
                OP_SHORT_TO_REG: r[w[11:8]] = {8'h00, w[7:0]};
                OP_ADD:          r[w[11:8]] = r[w[7:4]] + r[w[3:0]];
                OP_XOR:          r[w[11:8]] = r[w[7:4]] ^ r[w[3:0]];
                default:         ;
            endcase
        end
        vectors++;
        if (r[4] !== 16'h0022) begin
            miscompares++;
            $display("FAIL b2b_cpu_r4: got %h expected 0022", r[4]);
        end
    endtask

    task automatic test_gapped();
        bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [WS-1:0] gw  [3] = '{16'hA001, 16'hB002, 16'hC003};
        int  cyc, base, k;
        bit  stayed;
        start_clear(1'b0, 1'b0, cyc, stayed);
        base = wlog.size() + 1;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = pat[i];
            bus.in_data  = pat[i] ? gw[k] : WS'($urandom);
            bus.in_last  = pat[i] ? (k == 2) : 1'($urandom_range(1));
            step();
            vectors++;
            if (bus.mem_we !== pat[i]) begin
                miscompares++;
                $display("FAIL gap_we_%0d: got %b expected %b", i, bus.mem_we, pat[i]);
            end
            if (pat[i]) begin
                vectors++;
                if (bus.mem_addr !== AS'(k) || bus.mem_wdata !== gw[k]) begin
                    miscompares++;
                    $display("FAIL gap_write_%0d: got addr=%h data=%h expected %h %h",
                             k, bus.mem_addr, bus.mem_wdata, AS'(k), gw[k]);
                end
                k++;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        step();
        step();
        vectors++;
        if (done !== 1'b1 || wlog.size() - base != 3) begin
            miscompares++;
            $display("FAIL gap_done: got done=%b writes=%0d expected 1 3", done, wlog.size() - base);
        end
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 4; t++) begin
            n = (t == 0) ? 1 : $urandom_range(2, 60);
            for (int i = 0; i < n; i++) prog[i] = WS'($urandom);
            run_program($sformatf("rand%0d", t), n, (t == 0) ? 0 : 40);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < RS; i++) prog[i] = WS'($urandom_range(1, 16'hFFFF));
        run_program("full", RS, 0);
    endtask

    task automatic test_overflow();
        int cyc, acc, base, e;
        bit stayed;
        for (int i = 0; i < RS + 1; i++) prog[i] = WS'($urandom_range(1, 16'hFFFF));
        build_exp(RS + 1);
        start_clear(1'b1, 1'b0, cyc, stayed);
        base = wlog.size() + 1;
        drive_prog(RS + 1, 1'b0, 0, RS + 20, acc, cyc);
        vectors++;
        if (acc != RS) begin
            miscompares++;
            $display("FAIL ovf_accepted: got %0d words expected %0d", acc, RS);
        end
        vectors++;
        if (error !== 1'b1 || bus.in_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_status: got error=%b ready=%b cpu_reset=%b done=%b expected 1 0 1 0",
                     error, bus.in_ready, cpu_reset, done);
        end
        vectors++;
        e = ram_errors() + wlog_errors(base, RS);
        if (e != 0) begin
            miscompares++;
            $display("FAIL ovf_ram: got %0d bad words/writes expected 0", e);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, acc;
        bit stayed;
        for (int i = 0; i < 5; i++) prog[i] = WS'($urandom_range(1, 16'hFFFF));
        start_clear(1'b1, 1'b0, cyc, stayed);
        drive_prog(5, 1'b0, 0, 2, acc, cyc);
        step();
        vectors++;
        if (acc != 2 || ram[0] !== prog[0] || ram[1] !== prog[1]) begin
            miscompares++;
            $display("FAIL mid_preload: got %0d words ram0=%h ram1=%h expected 2 %h %h",
                     acc, ram[0], ram[1], prog[0], prog[1]);
        end
        start_clear(1'b0, 1'b0, cyc, stayed);
        vectors++;
        if (cyc != RS || !stayed || ram[0] !== '0 || ram[1] !== '0) begin
            miscompares++;
            $display("FAIL mid_reclear: got cycles=%0d held=%b ram0=%h ram1=%h expected %0d 1 0000 0000",
                     cyc, stayed, ram[0], ram[1], RS);
        end
        prog[0] = WS'($urandom_range(1, 16'hFFFF));
        run_program("mid_reload", 1, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        test_reset();
        test_clear();
        test_back_to_back();
        test_gapped();
        test_random();
        test_full();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
